// File: rtl/clock_reset_sequencer_if.sv
// Bus bundle for clock_reset_sequencer: control inputs, divided clocks,
// staggered resets, FSM debug state and the change-monitor stream.
//
// Handshake: mon_valid is a valid-only strobe with no ready. The consumer
// must take mon_time/mon_snap in every cycle where mon_valid is high; the
// payload is stable while valid and held between pulses. enable, div_load
// and div_value are sampled on every rising clock edge with no handshake.
interface clock_reset_sequencer_if #(
  parameter int NCH   = 4,
  parameter int DIV_W = 8,
  parameter int TS_W  = 32
);
  logic                 enable;
  logic [NCH-1:0]       div_load;
  logic [NCH*DIV_W-1:0] div_value;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       rst_out;
  logic                 seq_done;
  logic                 mon_valid;
  logic [TS_W-1:0]      mon_time;
  logic [2*NCH-1:0]     mon_snap;
  logic [1:0]           fsm_state;

  // Harness side: drives the controls, observes everything else.
  modport master (
    output enable, div_load, div_value,
    input  clk_out, rst_out, seq_done, mon_valid, mon_time, mon_snap, fsm_state
  );

  // Sequencer side.
  modport slave (
    input  enable, div_load, div_value,
    output clk_out, rst_out, seq_done, mon_valid, mon_time, mon_snap, fsm_state
  );
endinterface

// File: rtl/clock_reset_sequencer.sv
// Clock-enable / reset sequencer: NCH programmable divided clocks, resets
// released in staggered order after a fixed hold, and a change monitor that
// timestamps every change of {rst_out, clk_out}.
module clock_reset_sequencer #(
  parameter int NCH         = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5,
  parameter int RST_CYCLES  = 50,
  parameter int STAGGER     = 4,
  parameter int TS_W        = 32
) (
  input logic                    clock,
  input logic                    reset,
  clock_reset_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int SEQ_MAX = (RST_CYCLES > STAGGER) ? RST_CYCLES : STAGGER;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;

  state_t           state, state_nxt;
  logic [SEQ_W-1:0] seq_cnt, seq_cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [NCH-1:0]   rst_q, rst_nxt;
  logic             done_q, done_nxt;
  logic [NCH-1:0]   clk_vec;

  // Release FSM registers: state, edge counter, next channel to release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= HOLD;
      seq_cnt <= '0;
      idx     <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      seq_cnt <= seq_cnt_nxt;
      idx     <= idx_nxt;
      rst_q   <= rst_nxt;
      done_q  <= done_nxt;
    end
  end

  // Release FSM next state: hold all resets, then clear them one by one.
  always_comb begin
    state_nxt   = state;
    seq_cnt_nxt = seq_cnt + SEQ_W'(1);
    idx_nxt     = idx;
    rst_nxt     = rst_q;
    done_nxt    = done_q;
    case (state)
      HOLD: begin
        if (seq_cnt == SEQ_W'(RST_CYCLES - 1)) begin
          rst_nxt[0]  = 1'b0;
          seq_cnt_nxt = '0;
          if (NCH == 1) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = RELEASE;
            idx_nxt   = IDX_W'(1);
          end
        end
      end
      RELEASE: begin
        if (seq_cnt == SEQ_W'(STAGGER - 1)) begin
          rst_nxt[idx] = 1'b0;
          seq_cnt_nxt  = '0;
          if (idx == IDX_W'(NCH - 1)) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      RUN: begin
        // Terminal: counter parked so it cannot wrap.
        seq_cnt_nxt = seq_cnt;
      end
      default: begin
        state_nxt = HOLD;
      end
    endcase
  end

  // One divider per channel; a load restarts the phase but keeps the level.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             clk_q;

    // Divider: toggle on counter wrap, frozen by enable, load takes priority.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        div_q <= DIV_W'(DEFAULT_DIV);
        cnt_q <= '0;
        clk_q <= 1'b0;
      end else if (bus.div_load[i]) begin
        div_q <= bus.div_value[i*DIV_W +: DIV_W];
        cnt_q <= '0;
      end else if (bus.enable) begin
        if (div_q == '0) begin
          cnt_q <= '0;
        end else if (cnt_q == div_q - DIV_W'(1)) begin
          cnt_q <= '0;
          clk_q <= ~clk_q;
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
      end
    end

    assign clk_vec[i] = clk_q;
  end

  logic [TS_W-1:0]  ts;
  logic [2*NCH-1:0] prev_snap;
  logic [2*NCH-1:0] cur_snap;

  assign cur_snap = {rst_q, clk_vec};

  // Timestamp and change monitor: ts holds the index of the upcoming edge,
  // so the edge that produced a change one cycle ago is ts - 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts            <= '0;
      prev_snap     <= {{NCH{1'b1}}, {NCH{1'b0}}};
      bus.mon_valid <= 1'b0;
      bus.mon_time  <= '0;
      bus.mon_snap  <= {{NCH{1'b1}}, {NCH{1'b0}}};
    end else begin
      ts        <= ts + TS_W'(1);
      prev_snap <= cur_snap;
      if (cur_snap != prev_snap) begin
        bus.mon_valid <= 1'b1;
        bus.mon_snap  <= cur_snap;
        bus.mon_time  <= ts - TS_W'(1);
      end else begin
        bus.mon_valid <= 1'b0;
      end
    end
  end

  assign bus.clk_out   = clk_vec;
  assign bus.rst_out   = rst_q;
  assign bus.seq_done  = done_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer (8-bit timestamp build so the wrap is seen).
module tb_clock_reset_sequencer;
  localparam int NCH         = 4;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 5;
  localparam int RST_CYCLES  = 50;
  localparam int STAGGER     = 4;
  localparam int TS_W        = 8;
  localparam int EW          = TS_W + 2*NCH;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  clock_reset_sequencer_if #(.NCH(NCH), .DIV_W(DIV_W), .TS_W(TS_W)) bus ();

  clock_reset_sequencer #(
    .NCH(NCH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV),
    .RST_CYCLES(RST_CYCLES), .STAGGER(STAGGER), .TS_W(TS_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_n: edges since reset release. m_e[i]: enabled edges since the last
  // load/reset; a channel flips each time that count reaches a multiple of
  // its divisor. Reset i is held until edge RST_CYCLES-1 + i*STAGGER.
  int             m_n;
  int             m_div[NCH];
  int             m_e[NCH];
  logic [NCH-1:0] m_clk;
  logic [NCH-1:0] m_rst;
  logic           m_done;

  task automatic model_reset();
    m_n = 0;
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DEFAULT_DIV;
      m_e[i]   = 0;
    end
    m_clk  = '0;
    m_rst  = '1;
    m_done = 1'b0;
    exp_q.delete();
  endtask

  always @(posedge clock) begin
    logic [2*NCH-1:0] before_s;
    logic [2*NCH-1:0] after_s;
    if (reset) begin
      before_s = {m_rst, m_clk};
      for (int i = 0; i < NCH; i++) begin
        if (bus.div_load[i]) begin
          m_div[i] = int'(bus.div_value[i*DIV_W +: DIV_W]);
          m_e[i]   = 0;
        end else if (bus.enable && m_div[i] != 0) begin
          m_e[i]++;
          if (m_e[i] % m_div[i] == 0) m_clk[i] = ~m_clk[i];
        end
        m_rst[i] = (m_n < RST_CYCLES - 1 + i*STAGGER);
      end
      m_done  = (m_n >= RST_CYCLES - 1 + (NCH-1)*STAGGER);
      after_s = {m_rst, m_clk};
      if (after_s != before_s) exp_q.push_back({TS_W'(m_n), after_s});
      m_n++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (reset) begin
      check("clk_out", bus.clk_out, m_clk);
      check("rst_out", bus.rst_out, m_rst);
      check("seq_done", bus.seq_done, m_done);
      if (bus.mon_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mon_unexpected: got pulse time %0d snap %0h, expected no pulse",
                   bus.mon_time, bus.mon_snap);
        end else begin
          e = exp_q.pop_front();
          check("mon_time", bus.mon_time, e[EW-1:2*NCH]);
          check("mon_snap", bus.mon_snap, e[2*NCH-1:0]);
        end
      end
      // Only the change from the latest edge may still be outstanding.
      tests++;
      if (exp_q.size() > 1) begin
        fails++;
        $display("FAIL mon_missing: got %0d pending changes, expected at most 1", exp_q.size());
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clock);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_clk"}, bus.clk_out, 0);
    check({tag, "_rst"}, bus.rst_out, 4'hf);
    check({tag, "_done"}, bus.seq_done, 0);
    check({tag, "_mvalid"}, bus.mon_valid, 0);
    check({tag, "_mtime"}, bus.mon_time, 0);
    check({tag, "_msnap"}, bus.mon_snap, 8'hf0);
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      step();
      bus.enable   = ($urandom_range(0, 9) != 0);
      bus.div_load = '0;
      if ($urandom_range(0, 15) == 0) begin
        bus.div_load = NCH'($urandom_range(1, 15));
        for (int i = 0; i < NCH; i++)
          bus.div_value[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.enable    = 1'b1;
    bus.div_load  = '0;
    bus.div_value = '0;
    model_reset();
    repeat (3) step();
    check_reset_state("por");

    // Directed run from reset release; after step j, edges 0..j-1 are done.
    reset = 1'b1;
    for (int j = 1; j <= 170; j++) begin
      step();
      case (j)
        5:   check("ch0_rise4", bus.clk_out[0], 1);
        10:  check("ch0_fall9", bus.clk_out[0], 0);
        49:  check("rst_held48", bus.rst_out, 4'hf);
        50:  check("rst0_at49", bus.rst_out, 4'he);
        54:  check("rst1_at53", bus.rst_out, 4'hc);
        58:  check("rst2_at57", bus.rst_out, 4'h8);
        61:  check("done_pre61", bus.seq_done, 0);
        62:  begin
               check("rst3_at61", bus.rst_out, 4'h0);
               check("done_at61", bus.seq_done, 1);
             end
        100: begin
               bus.div_load = 4'b0010;
               bus.div_value[15:8] = 8'd2;
             end
        101: bus.div_load = '0;
        102: check("ch1_keep", bus.clk_out[1], 0);
        103: check("ch1_t102", bus.clk_out[1], 1);
        104: check("ch1_hold103", bus.clk_out[1], 1);
        105: check("ch1_t104", bus.clk_out[1], 0);
        107: check("ch1_t106", bus.clk_out[1], 1);
        114: bus.enable = 1'b0;
        121: begin
               bus.enable = 1'b1;
               check("ch0_frozen", bus.clk_out[0], 0);
             end
        122: check("ch0_shift7", bus.clk_out[0], 1);
        125: begin
               bus.div_load = 4'b1000;
               bus.div_value[31:24] = 8'd0;
             end
        126: bus.div_load = '0;
        160: begin
               bus.div_load = 4'b1000;
               bus.div_value[31:24] = 8'd1;
             end
        161: bus.div_load = '0;
        default: ;
      endcase
    end

    random_phase(700);

    // Asynchronous reset mid-cycle.
    step();
    #2 reset = 1'b0;
    #1 check_reset_state("async");
    model_reset();
    bus.enable   = 1'b1;
    bus.div_load = '0;
    repeat (2) step();
    reset = 1'b1;
    for (int j = 1; j <= 56; j++) begin
      step();
      if (j == 50) check("r2_rst0", bus.rst_out, 4'he);
      if (j == 54) check("r2_rst1", bus.rst_out, 4'hc);
    end
    // Reset during RELEASE, right after edge 55.
    #2 reset = 1'b0;
    #1 check_reset_state("release");
    model_reset();
    step();
    reset = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      step();
      if (j == 49) check("r3_held", bus.rst_out, 4'hf);
      if (j == 50) check("r3_rst0", bus.rst_out, 4'he);
    end

    random_phase(300);

    // Quiet tail so every recorded change drains.
    step();
    bus.enable   = 1'b0;
    bus.div_load = '0;
    repeat (20) step();
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
